pwm_deadtime: RTL and testbench



---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_deadtime_chan.sv | 98 +++++++++
 rtl/pwm_deadtime.sv | 130 +++++++++++++
 tb/tb_pwm_deadtime.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM-subsystem definitions: register offsets, channel stride,
// control/status bit positions and the dead-time FSM state encoding.
package pwm_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_PERIOD   = 4'h4;
    localparam logic [3:0] REG_DUTY     = 4'h8;
    localparam logic [3:0] REG_COUNTER  = 4'hC;
    localparam logic [3:0] REG_DEADTIME = REG_PERIOD;
    localparam logic [3:0] REG_STATUS   = REG_DUTY;

    localparam int CHAN_STRIDE = 16;
    localparam int CHAN_SHIFT  = $clog2(CHAN_STRIDE);

    localparam int CTRL_EN     = 0;
    localparam int CTRL_HI_INV = 1;
    localparam int CTRL_LO_INV = 2;
    localparam int STAT_FAULT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI_ON = 3'd1,
        ST_DT_HL = 3'd2,
        ST_LO_ON = 3'd3,
        ST_DT_LH = 3'd4
    } dt_state_e;

endpackage

// File: rtl/pwm_deadtime_chan.sv
// One complementary output channel: dead-band FSM, counter and
// registered raw drive levels, with pin polarity applied on the way out.
module pwm_deadtime_chan
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                hold,
    input  logic                hi_inv,
    input  logic                lo_inv,
    input  logic [DT_WIDTH-1:0] deadtime,
    input  logic                pwm_in,
    output dt_state_e           state,
    output logic                pwm_hi,
    output logic                pwm_lo
);

    logic [DT_WIDTH-1:0] cnt;
    logic                raw_hi;
    logic                raw_lo;

    // Raw levels are written alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            raw_hi <= 1'b0;
            raw_lo <= 1'b0;
        end else if (!en || hold) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            raw_hi <= 1'b0;
            raw_lo <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state  <= pwm_in ? ST_DT_LH : ST_DT_HL;
                    cnt    <= deadtime;
                    raw_hi <= 1'b0;
                    raw_lo <= 1'b0;
                end
                ST_HI_ON: begin
                    if (!pwm_in) begin
                        state  <= ST_DT_HL;
                        cnt    <= deadtime;
                        raw_hi <= 1'b0;
                    end
                end
                ST_DT_HL: begin
                    if (pwm_in) begin
                        state  <= ST_HI_ON;
                        raw_hi <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= ST_LO_ON;
                        raw_lo <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_in) begin
                        state  <= ST_DT_LH;
                        cnt    <= deadtime;
                        raw_lo <= 1'b0;
                    end
                end
                ST_DT_LH: begin
                    if (!pwm_in) begin
                        state  <= ST_LO_ON;
                        raw_lo <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= ST_HI_ON;
                        raw_hi <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    raw_hi <= 1'b0;
                    raw_lo <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_hi = raw_hi ^ hi_inv;
    assign pwm_lo = raw_lo ^ lo_inv;

    no_shoot_through: assert property (
        @(posedge clk) disable iff (rst) !(raw_hi && raw_lo)
    );

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary dead-band output stage with per-channel register window.
// Define DT_FAULT_EN to add the fault input and sticky per-channel fault flags.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter logic [31:0] DT_BASE_ADDR = 32'h4000_3100,
    parameter int          PWM_NUM      = 2,
    parameter int          DT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic               mem_we,
    input  logic               mem_re,
    output logic [31:0]        mem_rdata,
    input  logic [PWM_NUM-1:0] pwm_in,
    output logic [PWM_NUM-1:0] pwm_hi,
    output logic [PWM_NUM-1:0] pwm_lo
`ifdef DT_FAULT_EN
    ,
    input  logic               fault
`endif
);

    logic       sel;
    logic       wr;
    logic [3:0] ch;
    logic [3:0] off;

    assign sel = mem_addr[31:8] == DT_BASE_ADDR[31:8];
    assign wr  = mem_we && sel;
    assign ch  = mem_addr[CHAN_SHIFT +: 4];
    assign off = mem_addr[CHAN_SHIFT-1:0];

    logic [2:0]          ctrl [PWM_NUM];
    logic [DT_WIDTH-1:0] dt   [PWM_NUM];
    dt_state_e           st   [PWM_NUM];
    logic [PWM_NUM-1:0]  flag;
    logic [PWM_NUM-1:0]  hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PWM_NUM; i++) begin
                ctrl[i] <= '0;
                dt[i]   <= '0;
            end
        end else if (wr) begin
            for (int i = 0; i < PWM_NUM; i++) begin
                if (ch == 4'(i)) begin
                    if (off == REG_CTRL)
                        ctrl[i] <= mem_wdata[2:0];
                    if (off == REG_DEADTIME)
                        dt[i] <= mem_wdata[DT_WIDTH-1:0];
                end
            end
        end
    end

`ifdef DT_FAULT_EN
    // An active fault outranks a same-cycle clear so the flag cannot be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= '0;
        end else if (fault) begin
            flag <= '1;
        end else if (wr && off == REG_STATUS && mem_wdata[STAT_FAULT]) begin
            for (int i = 0; i < PWM_NUM; i++) begin
                if (ch == 4'(i))
                    flag[i] <= 1'b0;
            end
        end
    end

    assign hold = flag | {PWM_NUM{fault}};
`else
    assign flag = '0;
    assign hold = '0;
`endif

    always_comb begin
        mem_rdata = '0;
        if (sel && mem_re) begin
            for (int i = 0; i < PWM_NUM; i++) begin
                if (ch == 4'(i)) begin
                    case (off)
                        REG_CTRL: begin
                            mem_rdata[2:0] = ctrl[i];
                        end
                        REG_DEADTIME: begin
                            mem_rdata = 32'(dt[i]);
                        end
                        REG_STATUS: begin
                            mem_rdata[2:0]        = st[i];
                            mem_rdata[STAT_FAULT] = flag[i];
                        end
                        REG_COUNTER: begin
                            mem_rdata = '0;
                        end
                        default: begin
                            mem_rdata = '0;
                        end
                    endcase
                end
            end
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[31:DT_WIDTH];

    for (genvar g = 0; g < PWM_NUM; g++) begin : g_chan
        pwm_deadtime_chan #(
            .DT_WIDTH(DT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (ctrl[g][CTRL_EN]),
            .hold     (hold[g]),
            .hi_inv   (ctrl[g][CTRL_HI_INV]),
            .lo_inv   (ctrl[g][CTRL_LO_INV]),
            .deadtime (dt[g]),
            .pwm_in   (pwm_in[g]),
            .state    (st[g]),
            .pwm_hi   (pwm_hi[g]),
            .pwm_lo   (pwm_lo[g])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomised bench for pwm_deadtime against a timestamp-based model
// of the dead-band rules; define DT_FAULT_EN to exercise the fault path.
`timescale 1ns/1ps
module tb_pwm_deadtime;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic         mem_we = 1'b0;
    logic         mem_re = 1'b0;
    logic [31:0]  mem_rdata;
    logic [N-1:0] pwm = '0;
    logic [N-1:0] pwm_hi;
    logic [N-1:0] pwm_lo;
    logic         fault = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    pwm_deadtime #(
        .DT_BASE_ADDR(32'h4000_3100),
        .PWM_NUM(N),
        .DT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .pwm_in(pwm),
        .pwm_hi(pwm_hi),
        .pwm_lo(pwm_lo)
`ifdef DT_FAULT_EN
        ,
        .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    // Model: owner is the side that last held (or is heading back to) the
    // drive: 0 none, 1 high, 2 low. A dead band starts at edge ds with
    // length dl latched then; the other side wins once it has lasted dl+1 edges.
    int         owner [N];
    bit         dead  [N];
    int         ds    [N];
    int         dl    [N];
    logic [2:0] mctrl [N];
    logic [7:0] mdt   [N];
    bit         mflag [N];
    int         t;

    function automatic void model_reset();
        t = 0;
        for (int c = 0; c < N; c++) begin
            owner[c] = 0;
            dead[c]  = 0;
            ds[c]    = 0;
            dl[c]    = 0;
            mctrl[c] = '0;
            mdt[c]   = '0;
            mflag[c] = 0;
        end
    endfunction

    function automatic void model_step();
        bit         hold;
        bit         p;
        int         c2;
        logic [3:0] o;
        t++;
        for (int c = 0; c < N; c++) begin
            hold = 0;
`ifdef DT_FAULT_EN
            hold = fault || mflag[c];
`endif
            p = pwm[c];
            if (!mctrl[c][0] || hold) begin
                owner[c] = 0;
                dead[c]  = 0;
            end else if (owner[c] == 0) begin
                owner[c] = p ? 2 : 1;
                dead[c]  = 1;
                ds[c]    = t;
                dl[c]    = int'(mdt[c]);
            end else if (p == (owner[c] == 1)) begin
                dead[c] = 0;
            end else if (!dead[c]) begin
                dead[c] = 1;
                ds[c]   = t;
                dl[c]   = int'(mdt[c]);
            end else if (t - ds[c] >= dl[c] + 1) begin
                owner[c] = 3 - owner[c];
                dead[c]  = 0;
            end
        end
`ifdef DT_FAULT_EN
        if (fault)
            for (int c = 0; c < N; c++) mflag[c] = 1;
`endif
        if (mem_we && mem_addr[31:8] == 24'h400031) begin
            c2 = int'(mem_addr[7:4]);
            o  = mem_addr[3:0];
            if (c2 < N) begin
                if (o == 4'h0) mctrl[c2] = mem_wdata[2:0];
                if (o == 4'h4) mdt[c2] = mem_wdata[7:0];
`ifdef DT_FAULT_EN
                if (o == 4'h8 && mem_wdata[3] && !fault) mflag[c2] = 0;
`endif
            end
        end
    endfunction

    function automatic bit m_hi(input int c);
        return owner[c] == 1 && !dead[c];
    endfunction

    function automatic bit m_lo(input int c);
        return owner[c] == 2 && !dead[c];
    endfunction

    function automatic logic [31:0] exp_status(input int c);
        logic [31:0] s;
        s = '0;
        if (owner[c] == 1) s[2:0] = dead[c] ? 3'd2 : 3'd1;
        else if (owner[c] == 2) s[2:0] = dead[c] ? 3'd4 : 3'd3;
        s[3] = mflag[c];
        return s;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] v;
        int          c;
        v = '0;
        c = int'(a[7:4]);
        if (a[31:8] == 24'h400031 && c < N) begin
            if (a[3:0] == 4'h0) v = 32'(mctrl[c]);
            else if (a[3:0] == 4'h4) v = 32'(mdt[c]);
            else if (a[3:0] == 4'h8) v = exp_status(c);
        end
        return v;
    endfunction

    function automatic logic [31:0] addr(input int c, input logic [3:0] o);
        return 32'h4000_3100 | (32'(c) << 4) | 32'(o);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        mem_addr = a;
        mem_re   = 1'b1;
        #1;
        chk(tag, mem_rdata, exp_rd(a));
        mem_re = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        mem_we = 1'b0;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("hi%0d", c), 32'(pwm_hi[c]),
                32'(m_hi(c) ^ mctrl[c][1]));
            chk($sformatf("lo%0d", c), 32'(pwm_lo[c]),
                32'(m_lo(c) ^ mctrl[c][2]));
            rd(addr(c, 4'h8), $sformatf("stat%0d", c));
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        tick();
    endtask

    task automatic wr(input int c, input logic [3:0] o, input logic [31:0] d);
        bus_wr(addr(c, o), d);
    endtask

    task automatic rd_const(input int c, input logic [3:0] o,
                            input logic [31:0] exp, input string tag);
        mem_addr = addr(c, o);
        mem_re   = 1'b1;
        #1;
        chk(tag, mem_rdata, exp);
        mem_re = 1'b0;
    endtask

    // Counts both-low cycles after moving pwm_in to lvl until the
    // matching side comes on; bounded so a stuck output still ends.
    task automatic dead_len(input int c, input bit lvl, input int exp,
                            input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        pwm[c] = lvl;
        for (int k = 0; k < exp + 8; k++) begin
            if (!done) begin
                tick();
                if ((lvl ? pwm_hi[c] : pwm_lo[c]) == 1'b1) done = 1;
                else n++;
            end
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    int         lo_seen;
    int         runl [N];
    logic [3:0] ro;
    logic [31:0] rdat;
    logic [31:0] radr;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 32'(pwm_hi), 32'h0);
        chk("rst_lo", 32'(pwm_lo), 32'h0);
        rd(addr(0, 4'h0), "rst_ctrl");
        rd(addr(1, 4'h8), "rst_stat");
        rst = 1'b0;

        // DEADTIME=3, 10/10 toggling
        wr(0, 4'h4, 32'd3);
        wr(0, 4'h0, 32'd1);
        repeat (2) begin
            pwm[0] = 1'b1; run(10);
            pwm[0] = 1'b0; run(10);
        end
        pwm[0] = 1'b1; run(10);
        dead_len(0, 1'b0, 4, "dt3_fall");
        run(6);
        dead_len(0, 1'b1, 4, "dt3_rise");
        run(6);

        // DEADTIME=0, period-4 square on both channels
        wr(0, 4'h4, 32'd0);
        wr(1, 4'h4, 32'd0);
        wr(1, 4'h0, 32'd1);
        repeat (8) begin
            pwm = 2'b11; run(2);
            pwm = 2'b00; run(2);
        end
        pwm = 2'b11; run(4);
        dead_len(0, 1'b0, 1, "dt0_fall");
        run(3);
        dead_len(0, 1'b1, 1, "dt0_rise");

        // DEADTIME=5, short low pulses abort the dead band
        wr(0, 4'h4, 32'd5);
        pwm[0] = 1'b1; run(12);
        lo_seen = 0;
        repeat (3) begin
            pwm[0] = 1'b0;
            repeat (2) begin tick(); lo_seen += int'(pwm_lo[0]); end
            pwm[0] = 1'b1;
            repeat (8) begin tick(); lo_seen += int'(pwm_lo[0]); end
        end
        chk("abort_no_lo", 32'(lo_seen), 32'd0);
        chk("abort_hi_back", 32'(pwm_hi[0]), 32'd1);

        // inverted pins
        wr(0, 4'h0, 32'd7);
        run(14);
        wr(0, 4'h0, 32'd6);
        run(2);
        chk("inv_idle_hi", 32'(pwm_hi[0]), 32'd1);
        chk("inv_idle_lo", 32'(pwm_lo[0]), 32'd1);
        wr(0, 4'h0, 32'd0);

        // disable mid DT_LH with a long dead time
        wr(0, 4'h4, 32'd200);
        pwm[0] = 1'b1;
        wr(0, 4'h0, 32'd1);
        run(5);
        rd_const(0, 4'h8, 32'd4, "dt_lh_stat");
        wr(0, 4'h0, 32'd0);
        run(1);
        rd_const(0, 4'h8, 32'd0, "dis_idle");
        rd_const(0, 4'hC, 32'd0, "reg_c_zero");
        rd_const(3, 4'h0, 32'd0, "bad_chan");

        // asynchronous reset in the middle of a dead band
        pwm[0] = 1'b0;
        wr(0, 4'h0, 32'd5);
        run(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", 32'(pwm_hi), 32'h0);
        chk("arst_lo", 32'(pwm_lo), 32'h0);
        rd_const(0, 4'h8, 32'd0, "arst_stat");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        pwm = '0;

`ifdef DT_FAULT_EN
        wr(0, 4'h4, 32'd2);
        pwm = 2'b11;
        wr(0, 4'h0, 32'd1);
        run(8);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        chk("flt_hi", 32'(pwm_hi[0]), 32'd0);
        rd_const(0, 4'h8, 32'h8, "flt_stat");
        run(5);
        rd_const(0, 4'h8, 32'h8, "flt_hold");
        wr(0, 4'h8, 32'h8);
        run(1);
        rd_const(0, 4'h8, 32'd4, "flt_reent");
        run(6);
`endif

        // randomised traffic
        for (int c = 0; c < N; c++) runl[c] = 0;
        for (int k = 0; k < 2500; k++) begin
            for (int c = 0; c < N; c++) begin
                if (runl[c] == 0) begin
                    pwm[c]  = ~pwm[c];
                    runl[c] = $urandom_range(1, 12);
                end
                runl[c]--;
            end
`ifdef DT_FAULT_EN
            fault = ($urandom_range(0, 80) == 0);
`endif
            if (k % 50 == 25) begin
                wr((k / 50) % 2, 4'h8, 32'h8);
            end else if ($urandom_range(0, 7) == 0) begin
                ro   = 4'($urandom_range(0, 3) * 4);
                rdat = $urandom;
                if (ro == 4'h0 && $urandom_range(0, 4) != 0) rdat[0] = 1'b1;
                if (ro == 4'h4)
                    rdat = ($urandom_range(0, 9) == 0) ?
                           32'($urandom_range(0, 40)) : 32'($urandom_range(0, 6));
                radr = addr($urandom_range(0, 3), ro);
                if ($urandom_range(0, 9) == 0) radr = radr ^ 32'h100;
                bus_wr(radr, rdat);
            end else begin
                tick();
            end
            if ($urandom_range(0, 3) == 0) begin
                radr = addr($urandom_range(0, 3), 4'($urandom_range(0, 3) * 4));
                if ($urandom_range(0, 7) == 0) radr = radr ^ 32'h200;
                rd(radr, "rd_rand");
            end
        end
        fault = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
